// File: rtl/accesscode_tx_pkg.sv
// Shared types and constants for the access-code transmitter.
// Holds the FSM state enum, frame lengths and the air-bit selector.
package accesscode_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_PRE,
    ST_SYNC,
    ST_TRL
  } ac_state_e;

  localparam int PRE_LEN  = 4;
  localparam int SYNC_LEN = 64;
  localparam int TRL_LEN  = 4;
  localparam int SLOT_US  = 624;
  localparam int HALF_US  = 312;

  localparam logic [6:0] PRE_END  = 7'(PRE_LEN);
  localparam logic [6:0] SYNC_END = 7'(PRE_LEN + SYNC_LEN);
  localparam logic [6:0] TRL_END  = 7'(PRE_LEN + SYNC_LEN + TRL_LEN);

  // Preamble and trailer alternate so the stream never repeats a bit at a seam.
  function automatic logic ac_bit(
    input logic [63:0] sync,
    input logic [6:0]  idx
  );
    if (idx < PRE_END)
      ac_bit = idx[0] ? ~sync[0] : sync[0];
    else if (idx < SYNC_END)
      ac_bit = sync[6'(idx - PRE_END)];
    else
      ac_bit = idx[0] ? sync[63] : ~sync[63];
  endfunction

endpackage

// File: rtl/accesscode_tx_us_slot_timer.sv
// Microsecond slot timer: counts ticks from a start request and
// flags the half-slot and slot-end instants, then stops itself.
module us_slot_timer #(
  parameter int SLOT_US = 624,
  parameter int HALF_US = 312
) (
  input  logic clk_6M,
  input  logic rstz,
  input  logic tick,
  input  logic start,
  input  logic clr,
  output logic half_endp,
  output logic slot_endp
);

  localparam logic [9:0] SLOT_C = 10'(SLOT_US);
  localparam logic [9:0] HALF_C = 10'(HALF_US);

  logic [9:0] cnt;
  logic       run;

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      cnt <= '0;
      run <= 1'b1;
    end else if (run && tick) begin
      if (cnt == SLOT_C) begin
        cnt <= '0;
        run <= 1'b0;
      end else begin
        cnt <= cnt + 10'd1;
      end
    end
  end

  logic live;
  assign live = run & tick & ~clr & ~start;

  assign half_endp = live & (cnt == HALF_C);
  assign slot_endp = live & (cnt == SLOT_C);

endmodule

// File: rtl/accesscode_tx.sv
// Access-code transmitter: serializes preamble, sync word and optional
// trailer on the 1 us tick, and runs the slot timer from the first bit.
module accesscode_tx #(
  parameter int SLOT_US = accesscode_tx_pkg::SLOT_US,
  parameter int HALF_US = accesscode_tx_pkg::HALF_US
) (
  input  logic        clk_6M,
  input  logic        rstz,
  input  logic        p_1us,
  input  logic        tx_st_p,
  input  logic [63:0] ac_sync,
  input  logic        ac_trailer_en,
  input  logic        tx_abort,
  output logic        tx_bit,
  output logic        tx_bit_vld,
  output logic        ac_busy,
  output logic        ac_sync_end_p,
  output logic        ac_done_p,
  output logic        tx_tslotdly_endp,
  output logic        tx_halftslotdly_endp,
  output logic        ac_err_p
);

  import accesscode_tx_pkg::*;

  ac_state_e   state;
  ac_state_e   nxt_seg;
  logic [63:0] sync_q;
  logic        trl_q;
  logic [6:0]  bit_cnt;

  logic serial;
  logic accept;
  logic done_c;

  assign serial = (state == ST_PRE) | (state == ST_SYNC)
                | (state == ST_TRL);

  assign accept = (state == ST_IDLE) & tx_st_p
                & (ac_sync != '0) & ~tx_abort;

  assign done_c = serial & p_1us
                & (bit_cnt == (trl_q ? TRL_END : SYNC_END));

  assign ac_busy       = (state != ST_IDLE);
  assign ac_done_p     = done_c & ~tx_abort;
  assign ac_sync_end_p = serial & p_1us & ~tx_abort
                       & (state == ST_SYNC)
                       & (bit_cnt == SYNC_END);

  // Segment the bit about to be loaded belongs to.
  always_comb begin
    nxt_seg = ST_TRL;
    unique case (1'b1)
      bit_cnt < PRE_END:
        nxt_seg = ST_PRE;
      (bit_cnt >= PRE_END) && (bit_cnt < SYNC_END):
        nxt_seg = ST_SYNC;
      bit_cnt >= SYNC_END:
        nxt_seg = ST_TRL;
    endcase
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state      <= ST_IDLE;
      sync_q     <= '0;
      trl_q      <= 1'b0;
      bit_cnt    <= '0;
      tx_bit     <= 1'b0;
      tx_bit_vld <= 1'b0;
      ac_err_p   <= 1'b0;
    end else if (tx_abort) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      tx_bit     <= 1'b0;
      tx_bit_vld <= 1'b0;
      ac_err_p   <= 1'b0;
    end else begin
      ac_err_p <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (tx_st_p) begin
            if (ac_sync == '0) begin
              ac_err_p <= 1'b1;
            end else begin
              sync_q <= ac_sync;
              trl_q  <= ac_trailer_en;
              state  <= ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (p_1us) begin
            tx_bit     <= ac_bit(sync_q, 7'd0);
            tx_bit_vld <= 1'b1;
            bit_cnt    <= 7'd1;
            state      <= ST_PRE;
          end
        end
        default: begin
          if (p_1us) begin
            if (done_c) begin
              state      <= ST_IDLE;
              bit_cnt    <= '0;
              tx_bit     <= 1'b0;
              tx_bit_vld <= 1'b0;
            end else begin
              tx_bit  <= ac_bit(sync_q, bit_cnt);
              bit_cnt <= bit_cnt + 7'd1;
              state   <= nxt_seg;
            end
          end
        end
      endcase
    end
  end

  us_slot_timer #(
    .SLOT_US (SLOT_US),
    .HALF_US (HALF_US)
  ) u_slot (
    .clk_6M    (clk_6M),
    .rstz      (rstz),
    .tick      (p_1us),
    .start     (accept),
    .clr       (tx_abort),
    .half_endp (tx_halftslotdly_endp),
    .slot_endp (tx_tslotdly_endp)
  );

endmodule

// File: tb/tb_accesscode_tx.sv
// Directed bench for accesscode_tx: bit stream, pulse timing,
// zero-sync rejection, abort, ignored restarts and slot timing.
`timescale 1ns/1ps
module tb_accesscode_tx;

  logic        clk_6M = 1'b0;
  logic        rstz = 1'b0;
  logic        p_1us = 1'b0;
  logic        tx_st_p = 1'b0;
  logic [63:0] ac_sync = '0;
  logic        ac_trailer_en = 1'b0;
  logic        tx_abort = 1'b0;
  logic        tx_bit, tx_bit_vld, ac_busy;
  logic        ac_sync_end_p, ac_done_p;
  logic        tx_tslotdly_endp, tx_halftslotdly_endp, ac_err_p;

  accesscode_tx dut (
    .clk_6M               (clk_6M),
    .rstz                 (rstz),
    .p_1us                (p_1us),
    .tx_st_p              (tx_st_p),
    .ac_sync              (ac_sync),
    .ac_trailer_en        (ac_trailer_en),
    .tx_abort             (tx_abort),
    .tx_bit               (tx_bit),
    .tx_bit_vld           (tx_bit_vld),
    .ac_busy              (ac_busy),
    .ac_sync_end_p        (ac_sync_end_p),
    .ac_done_p            (ac_done_p),
    .tx_tslotdly_endp     (tx_tslotdly_endp),
    .tx_halftslotdly_endp (tx_halftslotdly_endp),
    .ac_err_p             (ac_err_p)
  );

  always #83 clk_6M = ~clk_6M;

  int n_vec = 0;
  int n_err = 0;
  int ph = 0;

  logic [63:0] sw  = 64'h4E7A_3C91_D052_B7E6;
  logic [63:0] sw2 = 64'hA5A5_0F0F_1234_5679;

  logic [71:0] cap;
  int   tk, done_tk, se_tk, half_tk, slot_tk;
  int   done_cnt, se_cnt, half_cnt, slot_cnt, vld_ticks;
  logic vld_pre, vld_after_done, busy_after_done, abort_idle;

  // p_1us is high one clock in six; sampling happens on the falling edge.
  task automatic cyc();
    @(posedge clk_6M);
    #1;
    ph = (ph == 5) ? 0 : ph + 1;
    p_1us = (ph == 5);
    @(negedge clk_6M);
  endtask

  task automatic start(input logic [63:0] s, input logic trl,
                       input bit coin);
    int g = 0;
    if (coin) while (!p_1us && g < 20) begin cyc(); g++; end
    else      while (p_1us && g < 20) begin cyc(); g++; end
    ac_sync = s;
    ac_trailer_en = trl;
    tx_st_p = 1'b1;
    cyc();
    tx_st_p = 1'b0;
  endtask

  // tk is the index of the tick at the coming rising edge (T0 first).
  task automatic collect(input int n_ticks, input int abort_tk,
                         input int rst_tk, input int chg_tk,
                         input logic [63:0] chg_val);
    int   cy = 0;
    logic aft_done = 1'b0;
    logic aft_abort = 1'b0;
    cap = '0;
    tk = 0;
    done_tk = -1; se_tk = -1; half_tk = -1; slot_tk = -1;
    done_cnt = 0; se_cnt = 0; half_cnt = 0; slot_cnt = 0;
    vld_ticks = 0;
    vld_pre = tx_bit_vld;
    vld_after_done = 1'bx; busy_after_done = 1'bx; abort_idle = 1'b0;
    while (tk < n_ticks) begin
      if (cy > n_ticks * 6 + 20) begin
        n_vec++; n_err++;
        $display("FAIL tick_budget got tk=%0d want %0d", tk, n_ticks);
        break;
      end
      tx_abort = 1'b0;
      tx_st_p = 1'b0;
      if (aft_abort) begin
        abort_idle = !tx_bit_vld && !tx_bit && !ac_busy;
        aft_abort = 1'b0;
      end
      if (aft_done) begin
        vld_after_done = tx_bit_vld;
        busy_after_done = ac_busy;
        aft_done = 1'b0;
      end
      done_cnt += int'(ac_done_p);
      se_cnt   += int'(ac_sync_end_p);
      half_cnt += int'(tx_halftslotdly_endp);
      slot_cnt += int'(tx_tslotdly_endp);
      if (p_1us) begin
        if (tk >= 1 && tk <= 72) cap[tk-1] = tx_bit;
        if (tk >= 1 && tx_bit_vld) vld_ticks++;
        if (ac_done_p) begin done_tk = tk; aft_done = 1'b1; end
        if (ac_sync_end_p) se_tk = tk;
        if (tx_halftslotdly_endp) half_tk = tk;
        if (tx_tslotdly_endp) slot_tk = tk;
        if (tk == abort_tk) begin tx_abort = 1'b1; aft_abort = 1'b1; end
        if (tk == rst_tk) tx_st_p = 1'b1;
        if (tk == chg_tk) ac_sync = chg_val;
        tk++;
      end
      cyc();
      cy++;
    end
    tx_abort = 1'b0;
    tx_st_p = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] o;
    rstz = 1'b0;
    ac_sync = sw;
    tx_st_p = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); cyc();
      o = {tx_bit, tx_bit_vld, ac_busy, ac_sync_end_p, ac_done_p,
           tx_tslotdly_endp, tx_halftslotdly_endp, ac_err_p};
      n_vec++;
      if (o !== 8'h00) begin
        n_err++;
        $display("FAIL reset_outputs got %b want 00000000", o);
      end
    end
    tx_st_p = 1'b0;
    rstz = 1'b1;
    cyc(); cyc();
    n_vec++;
    if (ac_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle busy got %b want 0", ac_busy);
    end
  endtask

  task automatic test_trailer();
    start(sw, 1'b1, 1'b0);
    n_vec++;
    if (ac_busy !== 1'b1) begin
      n_err++;
      $display("FAIL trl_busy got %b want 1", ac_busy);
    end
    collect(80, -1, -1, -1, '0);
    n_vec++;
    if (cap !== {4'b0101, sw, 4'b1010}) begin
      n_err++;
      $display("FAIL trl_bits got %h want %h", cap, {4'b0101, sw, 4'b1010});
    end
    n_vec++;
    if (done_tk !== 72 || done_cnt !== 1) begin
      n_err++;
      $display("FAIL trl_done got T%0d x%0d want T72 x1", done_tk, done_cnt);
    end
    n_vec++;
    if (se_tk !== 68 || se_cnt !== 1) begin
      n_err++;
      $display("FAIL trl_sync_end got T%0d x%0d want T68 x1", se_tk, se_cnt);
    end
    n_vec++;
    if (vld_pre !== 1'b0 || vld_ticks !== 72) begin
      n_err++;
      $display("FAIL trl_vld got pre=%b ticks=%0d want pre=0 ticks=72",
               vld_pre, vld_ticks);
    end
    n_vec++;
    if (vld_after_done !== 1'b0 || busy_after_done !== 1'b0) begin
      n_err++;
      $display("FAIL trl_after_done got vld=%b busy=%b want 0 0",
               vld_after_done, busy_after_done);
    end
  endtask

  task automatic test_no_trailer();
    start(sw, 1'b0, 1'b1);
    collect(80, -1, -1, -1, '0);
    n_vec++;
    if (cap !== {4'b0000, sw, 4'b1010}) begin
      n_err++;
      $display("FAIL ntrl_bits got %h want %h", cap, {4'b0000, sw, 4'b1010});
    end
    n_vec++;
    if (done_tk !== 68 || se_tk !== 68) begin
      n_err++;
      $display("FAIL ntrl_done got done T%0d end T%0d want T68 T68",
               done_tk, se_tk);
    end
    n_vec++;
    if (vld_after_done !== 1'b0 || vld_ticks !== 68) begin
      n_err++;
      $display("FAIL ntrl_vld got after=%b ticks=%0d want 0 68",
               vld_after_done, vld_ticks);
    end
  endtask

  task automatic test_zero_sync();
    ac_sync = '0;
    tx_st_p = 1'b1;
    cyc();
    tx_st_p = 1'b0;
    n_vec++;
    if (ac_err_p !== 1'b1 || ac_busy !== 1'b0) begin
      n_err++;
      $display("FAIL zero_err got err=%b busy=%b want 1 0", ac_err_p, ac_busy);
    end
    cyc();
    n_vec++;
    if (ac_err_p !== 1'b0) begin
      n_err++;
      $display("FAIL zero_err_width got %b want 0", ac_err_p);
    end
    collect(10, -1, -1, -1, '0);
    n_vec++;
    if (vld_ticks !== 0 || done_cnt !== 0 || cap !== '0) begin
      n_err++;
      $display("FAIL zero_no_bits got vld=%0d done=%0d want 0 0",
               vld_ticks, done_cnt);
    end
  endtask

  task automatic test_abort();
    start(sw, 1'b1, 1'b0);
    collect(330, 30, -1, -1, '0);
    n_vec++;
    if (abort_idle !== 1'b1) begin
      n_err++;
      $display("FAIL abort_idle got %b want 1", abort_idle);
    end
    n_vec++;
    if (cap !== {42'b0, sw[25:0], 4'b1010} || vld_ticks !== 30) begin
      n_err++;
      $display("FAIL abort_bits got %h/%0d want %h/30", cap, vld_ticks,
               {42'b0, sw[25:0], 4'b1010});
    end
    n_vec++;
    if (done_cnt !== 0 || se_cnt !== 0 || half_cnt !== 0 || slot_cnt !== 0)
    begin
      n_err++;
      $display("FAIL abort_pulses got done=%0d end=%0d half=%0d slot=%0d want 0",
               done_cnt, se_cnt, half_cnt, slot_cnt);
    end
    start(sw2, 1'b1, 1'b0);
    collect(80, -1, -1, -1, '0);
    n_vec++;
    if (cap !== {4'b1010, sw2, 4'b0101} || done_tk !== 72) begin
      n_err++;
      $display("FAIL abort_restart got %h T%0d want %h T72", cap, done_tk,
               {4'b1010, sw2, 4'b0101});
    end
  endtask

  task automatic test_back_to_back();
    start(sw, 1'b1, 1'b0);
    collect(80, -1, 10, 20, sw2);
    n_vec++;
    if (cap !== {4'b0101, sw, 4'b1010} || done_tk !== 72) begin
      n_err++;
      $display("FAIL b2b_bits got %h T%0d want %h T72", cap, done_tk,
               {4'b0101, sw, 4'b1010});
    end
    n_vec++;
    if (busy_after_done !== 1'b0 || done_cnt !== 1) begin
      n_err++;
      $display("FAIL b2b_idle got busy=%b done=%0d want 0 1",
               busy_after_done, done_cnt);
    end
    ac_sync = sw;
  endtask

  task automatic test_slot();
    start(sw2, 1'b0, 1'b1);
    collect(630, -1, -1, -1, '0);
    n_vec++;
    if (half_tk !== 312 || half_cnt !== 1) begin
      n_err++;
      $display("FAIL slot_half got T%0d x%0d want T312 x1", half_tk, half_cnt);
    end
    n_vec++;
    if (slot_tk !== 624 || slot_cnt !== 1) begin
      n_err++;
      $display("FAIL slot_end got T%0d x%0d want T624 x1", slot_tk, slot_cnt);
    end
    n_vec++;
    if (done_tk !== 68 || cap !== {4'b0000, sw2, 4'b0101}) begin
      n_err++;
      $display("FAIL slot_frame got T%0d %h want T68 %h", done_tk, cap,
               {4'b0000, sw2, 4'b0101});
    end
  endtask

  initial begin
    test_reset();
    test_trailer();
    test_no_trailer();
    test_zero_sync();
    test_abort();
    test_back_to_back();
    test_slot();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
